// File: rtl/ll_engine_scheduler_pkg.sv
// rtl/ll_engine_scheduler_pkg.sv - linked-list hash table types shared by the scheduler and its RAM mux
package ll_engine_scheduler_pkg;

  localparam int LL_TABLE_ADDR_WIDTH = 8;
  localparam int LL_KEY_WIDTH        = 16;
  localparam int LL_VALUE_WIDTH      = 16;
  localparam int LL_ENG_NUM          = 3;
  localparam int LL_ENG_IDX_W        = 2;

  typedef enum logic [1:0] {
    LL_OP_SEARCH = 2'd0,
    LL_OP_INSERT = 2'd1,
    LL_OP_DELETE = 2'd2
  } ll_ht_opcode_t;

  typedef enum logic [2:0] {
    LL_SEARCH_FOUND       = 3'd0,
    LL_SEARCH_NOT_FOUND   = 3'd1,
    LL_INSERT_SUCCESS     = 3'd2,
    LL_INSERT_NOT_SUCCESS = 3'd3,
    LL_DELETE_SUCCESS     = 3'd4,
    LL_DELETE_NOT_SUCCESS = 3'd5,
    LL_CMD_ILLEGAL        = 3'd6
  } ll_ht_rescode_t;

  // opcode is a raw 2-bit field so an illegal encoding can be carried and echoed back
  typedef struct packed {
    logic [1:0]                opcode;
    logic [LL_KEY_WIDTH-1:0]   key;
    logic [LL_VALUE_WIDTH-1:0] value;
  } ll_ht_cmd_t;

  typedef struct packed {
    ll_ht_cmd_t                     cmd;
    logic [LL_TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                           head_ptr_val;
  } ll_ht_pdata_t;

  typedef struct packed {
    ll_ht_cmd_t     cmd;
    ll_ht_rescode_t rescode;
  } ll_ht_result_t;

  typedef struct packed {
    logic [LL_KEY_WIDTH-1:0]        key;
    logic [LL_VALUE_WIDTH-1:0]      value;
    logic [LL_TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                           next_ptr_val;
  } ll_ram_data_t;

  typedef enum logic [2:0] {
    IDLE_S     = 3'd0,
    DISPATCH_S = 3'd1,
    RUN_S      = 3'd2,
    COOL_S     = 3'd3,
    RESP_S     = 3'd4
  } ll_sched_state_t;

  function automatic logic ll_opcode_legal(input logic [1:0] op);
    return (op != 2'd3);
  endfunction

  function automatic logic [LL_ENG_IDX_W-1:0] ll_opcode2eng(input logic [1:0] op);
    case (op)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ll_ram_port_mux.sv
// rtl/ll_ram_port_mux.sv - selects one engine's data-RAM rd/wr port; enables pass only while granted
module ll_ram_port_mux
  import ll_engine_scheduler_pkg::*;
#(
  parameter int A_WIDTH = LL_TABLE_ADDR_WIDTH
) (
  input  logic [LL_ENG_IDX_W-1:0]             sel_i,
  input  logic                                grant_i,
  input  logic [LL_ENG_NUM-1:0][A_WIDTH-1:0]  rd_addr_i,
  input  logic [LL_ENG_NUM-1:0]               rd_en_i,
  input  logic [LL_ENG_NUM-1:0][A_WIDTH-1:0]  wr_addr_i,
  input  ll_ram_data_t [LL_ENG_NUM-1:0]       wr_data_i,
  input  logic [LL_ENG_NUM-1:0]               wr_en_i,
  output logic [A_WIDTH-1:0]                  rd_addr_o,
  output logic                                rd_en_o,
  output logic [A_WIDTH-1:0]                  wr_addr_o,
  output ll_ram_data_t                        wr_data_o,
  output logic                                wr_en_o
);

  always_comb begin
    rd_addr_o = '0;
    rd_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    wr_en_o   = 1'b0;
    for (int i = 0; i < LL_ENG_NUM; i++) begin
      if (sel_i == LL_ENG_IDX_W'(i)) begin
        rd_addr_o = rd_addr_i[i];
        rd_en_o   = rd_en_i[i] & grant_i;
        wr_addr_o = wr_addr_i[i];
        wr_data_o = wr_data_i[i];
        wr_en_o   = wr_en_i[i] & grant_i;
      end
    end
  end

endmodule

// File: rtl/ll_engine_scheduler.sv
// rtl/ll_engine_scheduler.sv - one-task-in-flight dispatcher for the search/insert/delete engines
module ll_engine_scheduler
  import ll_engine_scheduler_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = LL_TABLE_ADDR_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  ll_ht_pdata_t                        task_i,
  input  logic                                task_valid_i,
  output logic                                task_ready_o,
  output ll_ht_pdata_t                        eng_task_o,
  output logic [LL_ENG_NUM-1:0]               eng_task_valid_o,
  input  logic [LL_ENG_NUM-1:0]               eng_task_ready_i,
  input  logic [LL_ENG_NUM-1:0][A_WIDTH-1:0]  eng_rd_addr_i,
  input  logic [LL_ENG_NUM-1:0]               eng_rd_en_i,
  input  logic [LL_ENG_NUM-1:0][A_WIDTH-1:0]  eng_wr_addr_i,
  input  ll_ram_data_t [LL_ENG_NUM-1:0]       eng_wr_data_i,
  input  logic [LL_ENG_NUM-1:0]               eng_wr_en_i,
  input  ll_ht_result_t [LL_ENG_NUM-1:0]      eng_result_i,
  input  logic [LL_ENG_NUM-1:0]               eng_result_valid_i,
  output logic [LL_ENG_NUM-1:0]               eng_result_ready_o,
  output logic [A_WIDTH-1:0]                  rd_addr_o,
  output logic                                rd_en_o,
  output logic [A_WIDTH-1:0]                  wr_addr_o,
  output ll_ram_data_t                        wr_data_o,
  output logic                                wr_en_o,
  output ll_ht_result_t                       result_o,
  output logic                                result_valid_o,
  input  logic                                result_ready_i,
  output logic                                busy_o
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

  ll_sched_state_t         state_q, state_d;
  ll_ht_pdata_t            task_q, task_d;
  ll_ht_result_t           result_q, result_d;
  logic [LL_ENG_IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    grant;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE_S;
      task_q   <= '0;
      result_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      task_q   <= task_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    task_d             = task_q;
    result_d           = result_q;
    sel_d              = sel_q;
    cnt_d              = cnt_q;
    task_ready_o       = (state_q == IDLE_S);
    eng_task_valid_o   = '0;
    eng_result_ready_o = '0;
    result_valid_o     = 1'b0;
    grant              = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (task_valid_i) begin
          task_d = task_i;
          if (ll_opcode_legal(task_i.cmd.opcode)) begin
            sel_d   = ll_opcode2eng(task_i.cmd.opcode);
            state_d = DISPATCH_S;
          end else begin
            // illegal opcodes never touch an engine; answer directly
            sel_d            = '0;
            result_d.cmd     = task_i.cmd;
            result_d.rescode = LL_CMD_ILLEGAL;
            state_d          = RESP_S;
          end
        end
      end
      DISPATCH_S: begin
        eng_task_valid_o[sel_q] = 1'b1;
        if (eng_task_ready_i[sel_q]) state_d = RUN_S;
      end
      RUN_S: begin
        grant                     = 1'b1;
        eng_result_ready_o[sel_q] = 1'b1;
        if (eng_result_valid_i[sel_q]) begin
          result_d = eng_result_i[sel_q];
          cnt_d    = '0;
          state_d  = COOL_S;
        end
      end
      COOL_S: begin
        // let reads already issued return to the engine before the next task can start
        if (cnt_q == CNT_LAST) state_d = RESP_S;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP_S: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  ll_ram_port_mux #(.A_WIDTH(A_WIDTH)) u_ram_port_mux (
    .sel_i     (sel_q),
    .grant_i   (grant),
    .rd_addr_i (eng_rd_addr_i),
    .rd_en_i   (eng_rd_en_i),
    .wr_addr_i (eng_wr_addr_i),
    .wr_data_i (eng_wr_data_i),
    .wr_en_i   (eng_wr_en_i),
    .rd_addr_o (rd_addr_o),
    .rd_en_o   (rd_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .wr_en_o   (wr_en_o)
  );

  assign eng_task_o = task_q;
  assign result_o   = result_q;
  assign busy_o     = (state_q != IDLE_S);

  logic [LL_ENG_NUM-1:0] sel_onehot;
  assign sel_onehot = LL_ENG_NUM'(1) << sel_q;

  a_foreign_result : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == RUN_S) |-> ((eng_result_valid_i & ~sel_onehot) == '0));

endmodule

// File: tb/tb_ll_engine_scheduler.sv
// tb/tb_ll_engine_scheduler.sv - directed self-checking bench for ll_engine_scheduler
module tb_ll_engine_scheduler;
  import ll_engine_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  ll_ht_pdata_t  task_in, eng_task, eng_task4;
  logic          task_valid, task_ready, t4_valid, t4_ready;
  logic [2:0]    eng_task_valid, eng_task_valid4, eng_task_ready;
  logic [2:0][7:0] eng_rd_addr, eng_wr_addr;
  logic [2:0]    eng_rd_en, eng_wr_en, eng_result_valid, eng_result_ready, eng_result_ready4;
  ll_ram_data_t  [2:0] eng_wr_data;
  ll_ht_result_t [2:0] eng_result;
  logic [7:0]    rd_addr, wr_addr, rd_addr4, wr_addr4;
  logic          rd_en, wr_en, rd_en4, wr_en4;
  ll_ram_data_t  wr_data, wr_data4;
  ll_ht_result_t result, result4, exp_res;
  logic          result_valid, result_ready, busy;
  logic          result_valid4, result_ready4, busy4;

  int checks = 0;
  int errors = 0;
  int n;

  ll_engine_scheduler #(.RAM_LATENCY(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .task_i(task_in), .task_valid_i(task_valid), .task_ready_o(task_ready),
    .eng_task_o(eng_task), .eng_task_valid_o(eng_task_valid), .eng_task_ready_i(eng_task_ready),
    .eng_rd_addr_i(eng_rd_addr), .eng_rd_en_i(eng_rd_en),
    .eng_wr_addr_i(eng_wr_addr), .eng_wr_data_i(eng_wr_data), .eng_wr_en_i(eng_wr_en),
    .eng_result_i(eng_result), .eng_result_valid_i(eng_result_valid), .eng_result_ready_o(eng_result_ready),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_en_o(wr_en),
    .result_o(result), .result_valid_o(result_valid), .result_ready_i(result_ready), .busy_o(busy)
  );

  ll_engine_scheduler #(.RAM_LATENCY(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .task_i(task_in), .task_valid_i(t4_valid), .task_ready_o(t4_ready),
    .eng_task_o(eng_task4), .eng_task_valid_o(eng_task_valid4), .eng_task_ready_i(eng_task_ready),
    .eng_rd_addr_i(eng_rd_addr), .eng_rd_en_i(eng_rd_en),
    .eng_wr_addr_i(eng_wr_addr), .eng_wr_data_i(eng_wr_data), .eng_wr_en_i(eng_wr_en),
    .eng_result_i(eng_result), .eng_result_valid_i(eng_result_valid), .eng_result_ready_o(eng_result_ready4),
    .rd_addr_o(rd_addr4), .rd_en_o(rd_en4), .wr_addr_o(wr_addr4), .wr_data_o(wr_data4), .wr_en_o(wr_en4),
    .result_o(result4), .result_valid_o(result_valid4), .result_ready_i(result_ready4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic ll_ht_pdata_t mk_task(input logic [1:0] op, input logic [15:0] key);
    ll_ht_pdata_t t;
    t = '0;
    t.cmd.opcode = op;
    t.cmd.key    = key;
    t.cmd.value  = 16'h00ab;
    return t;
  endfunction

  function automatic ll_ht_result_t mk_res(input logic [1:0] op, input logic [15:0] key,
                                           input ll_ht_rescode_t rc);
    ll_ht_result_t r;
    r = '0;
    r.cmd.opcode = op;
    r.cmd.key    = key;
    r.cmd.value  = 16'h00ab;
    r.rescode    = rc;
    return r;
  endfunction

  task automatic clear_eng();
    eng_task_ready   = '0;
    eng_rd_addr      = '0;
    eng_rd_en        = '0;
    eng_wr_addr      = '0;
    eng_wr_data      = '0;
    eng_wr_en        = '0;
    eng_result       = '0;
    eng_result_valid = '0;
  endtask

  // waits for result_valid_o with a bound; n ends as the number of cycles waited
  task automatic wait_result(input int limit);
    n = 0;
    while (!result_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; task_in = '0; task_valid = 1'b0; t4_valid = 1'b0;
    result_ready = 1'b0; result_ready4 = 1'b0;
    clear_eng();
    eng_rd_en = 3'b111; eng_wr_en = 3'b111;
    tick(); tick();
    check("rst_busy",           64'(busy), 64'(0));
    check("rst_task_ready",     64'(task_ready), 64'(1));
    check("rst_eng_task_valid", 64'(eng_task_valid), 64'(0));
    check("rst_eng_res_ready",  64'(eng_result_ready), 64'(0));
    check("rst_result_valid",   64'(result_valid), 64'(0));
    check("rst_rd_en",          64'(rd_en), 64'(0));
    check("rst_wr_en",          64'(wr_en), 64'(0));
    check("rst_result",         64'(result), 64'(0));
    check("rst_eng_task",       64'(eng_task), 64'(0));
    clear_eng();
    rst_n = 1'b1;
    tick();

    // 1) insert, engine ready in first dispatch cycle, result after 2-cycle cooldown
    task_in = mk_task(LL_OP_INSERT, 16'h0012); task_valid = 1'b1;
    #1 check("t1_task_ready", 64'(task_ready), 64'(1));
    tick();
    task_valid = 1'b0; eng_task_ready = 3'b010;
    #1 check("t1_dispatch_valid", 64'(eng_task_valid), 64'(3'b010));
    check("t1_eng_task_key", 64'(eng_task.cmd.key), 64'(16'h0012));
    check("t1_busy",         64'(busy), 64'(1));
    check("t1_not_ready",    64'(task_ready), 64'(0));
    tick();
    eng_task_ready = '0; eng_rd_en = 3'b010; eng_rd_addr[1] = 8'h03;
    #1 check("t1_valid_dropped", 64'(eng_task_valid), 64'(0));
    check("t1_res_ready", 64'(eng_result_ready), 64'(3'b010));
    check("t1_rd_en",     64'(rd_en), 64'(1));
    check("t1_rd_addr",   64'(rd_addr), 64'(8'h03));
    tick();
    eng_rd_en = '0; eng_wr_en = 3'b010; eng_wr_addr[1] = 8'h07; eng_wr_data[1].key = 16'h0012;
    eng_result[1] = mk_res(LL_OP_INSERT, 16'h0012, LL_INSERT_SUCCESS); eng_result_valid = 3'b010;
    #1 check("t1_wr_en_last", 64'(wr_en), 64'(1));
    check("t1_wr_addr", 64'(wr_addr), 64'(8'h07));
    check("t1_wr_key",  64'(wr_data.key), 64'(16'h0012));
    tick();
    eng_result_valid = '0;
    for (int i = 0; i < 2; i++) begin
      #1 check("t1_cool_wr_en", 64'(wr_en), 64'(0));
      check("t1_cool_res_valid", 64'(result_valid), 64'(0));
      check("t1_cool_res_ready", 64'(eng_result_ready), 64'(0));
      tick();
    end
    #1 check("t1_res_valid", 64'(result_valid), 64'(1));
    check("t1_rescode", 64'(result.rescode), 64'(LL_INSERT_SUCCESS));
    check("t1_res_key", 64'(result.cmd.key), 64'(16'h0012));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0; clear_eng();
    #1 check("t1_idle_ready", 64'(task_ready), 64'(1));
    check("t1_idle_res_valid", 64'(result_valid), 64'(0));
    tick();

    // 2) search while the delete engine tries to use the RAM
    task_in = mk_task(LL_OP_SEARCH, 16'h0012); task_valid = 1'b1;
    tick();
    task_valid = 1'b0; eng_task_ready = 3'b001;
    #1 check("t2_dispatch_valid", 64'(eng_task_valid), 64'(3'b001));
    tick();
    eng_task_ready = '0; eng_rd_en = 3'b101; eng_rd_addr[0] = 8'h09; eng_rd_addr[2] = 8'h05;
    eng_wr_en = 3'b100; eng_wr_addr[2] = 8'h05;
    #1 check("t2_rd_en",     64'(rd_en), 64'(1));
    check("t2_rd_addr",      64'(rd_addr), 64'(8'h09));
    check("t2_wr_en_del",    64'(wr_en), 64'(0));
    check("t2_res_ready",    64'(eng_result_ready), 64'(3'b001));
    tick();
    eng_rd_en = 3'b100;
    #1 check("t2_rd_en_del_only", 64'(rd_en), 64'(0));
    check("t2_rd_addr_search", 64'(rd_addr), 64'(8'h09));
    tick();
    eng_rd_en = '0; eng_wr_en = '0;
    eng_result[0] = mk_res(LL_OP_SEARCH, 16'h0012, LL_SEARCH_FOUND); eng_result_valid = 3'b001;
    tick();
    eng_result_valid = '0;
    wait_result(10);
    check("t2_cool_cycles", 64'(n), 64'(2));
    exp_res = mk_res(LL_OP_SEARCH, 16'h0012, LL_SEARCH_FOUND);

    // 3) client stalls the result for 5 cycles while a new task waits
    task_in = mk_task(LL_OP_DELETE, 16'h0034); task_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("t3_result_stable", 64'(result), 64'(exp_res));
      check("t3_result_valid", 64'(result_valid), 64'(1));
      check("t3_task_ready",   64'(task_ready), 64'(0));
      tick();
    end
    result_ready = 1'b1;
    #1 check("t3_no_same_cycle_accept", 64'(task_ready), 64'(0));
    tick();
    result_ready = 1'b0;
    #1 check("t3_next_ready", 64'(task_ready), 64'(1));
    check("t3_res_valid_low", 64'(result_valid), 64'(0));
    tick();
    task_valid = 1'b0;
    #1 check("t3_dispatch_del", 64'(eng_task_valid), 64'(3'b100));
    check("t3_eng_task_key", 64'(eng_task.cmd.key), 64'(16'h0034));
    eng_task_ready = 3'b100;
    tick();
    eng_task_ready = '0;
    eng_result[2] = mk_res(LL_OP_DELETE, 16'h0034, LL_DELETE_SUCCESS); eng_result_valid = 3'b100;
    tick();
    eng_result_valid = '0;
    wait_result(10);
    check("t3_cool_cycles", 64'(n), 64'(2));
    check("t3_rescode", 64'(result.rescode), 64'(LL_DELETE_SUCCESS));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0; clear_eng();

    // 4) illegal opcode answers directly
    task_in = mk_task(2'd3, 16'h0055); task_valid = 1'b1;
    tick();
    task_valid = 1'b0;
    #1 check("t4_no_dispatch", 64'(eng_task_valid), 64'(0));
    check("t4_res_valid", 64'(result_valid), 64'(1));
    check("t4_rescode",   64'(result.rescode), 64'(LL_CMD_ILLEGAL));
    check("t4_opcode",    64'(result.cmd.opcode), 64'(2'd3));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    #1 check("t4_idle", 64'(task_ready), 64'(1));
    tick();

    // 5) reset while the insert engine is writing
    task_in = mk_task(LL_OP_INSERT, 16'h0077); task_valid = 1'b1;
    tick();
    task_valid = 1'b0; eng_task_ready = 3'b010;
    tick();
    eng_task_ready = '0; eng_wr_en = 3'b010; eng_wr_addr[1] = 8'h0a;
    #1 check("t5_wr_en_run", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1 check("t5_wr_en_rst", 64'(wr_en), 64'(0));
    check("t5_busy_rst", 64'(busy), 64'(0));
    check("t5_res_ready_rst", 64'(eng_result_ready), 64'(0));
    tick();
    check("t5_res_valid_rst", 64'(result_valid), 64'(0));
    rst_n = 1'b1; clear_eng();
    tick();
    check("t5_busy_after", 64'(busy), 64'(0));
    check("t5_ready_after", 64'(task_ready), 64'(1));

    // 6) RAM_LATENCY=4 instance: four dead cycles, then result
    task_in = mk_task(LL_OP_SEARCH, 16'h0066); t4_valid = 1'b1;
    #1 check("t6_ready", 64'(t4_ready), 64'(1));
    tick();
    t4_valid = 1'b0; eng_task_ready = 3'b001;
    #1 check("t6_dispatch", 64'(eng_task_valid4), 64'(3'b001));
    tick();
    eng_task_ready = '0; eng_rd_en = 3'b001;
    eng_result[0] = mk_res(LL_OP_SEARCH, 16'h0066, LL_SEARCH_NOT_FOUND); eng_result_valid = 3'b001;
    #1 check("t6_rd_en_run", 64'(rd_en4), 64'(1));
    tick();
    eng_result_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #1 check("t6_cool_rd_en", 64'(rd_en4), 64'(0));
      check("t6_cool_res_valid", 64'(result_valid4), 64'(0));
      tick();
    end
    #1 check("t6_res_valid", 64'(result_valid4), 64'(1));
    check("t6_rescode", 64'(result4.rescode), 64'(LL_SEARCH_NOT_FOUND));
    result_ready4 = 1'b1;
    tick();
    result_ready4 = 1'b0; clear_eng();
    #1 check("t6_idle", 64'(busy4), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
